// File: rtl/cipher_out_unpacker.sv
// Buffers 128-bit cipher blocks in a FIFO and replays them as WORD_W-bit words over valid/ready.
// Word 0 appears the cycle after the block is written; words hold under backpressure; credit limits in-flight blocks.
module cipher_out_unpacker #(
  parameter int DEPTH  = 4,
  parameter int WORD_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     issue,
  input  logic                     blk_valid,
  input  logic [0:127]             blk_data,
  output logic                     can_issue,
  output logic                     word_valid,
  input  logic                     word_ready,
  output logic [WORD_W-1:0]        word_data,
  output logic                     word_last,
  output logic [$clog2(DEPTH):0]   blk_count,
  output logic                     overflow
);

  localparam int NW = 128 / WORD_W;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int KW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [KW-1:0] LAST_K  = KW'(NW - 1);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [KW-1:0] k_q, k_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [0:127]  mem_q [DEPTH];

  logic          xfer;
  logic          pop;
  logic          push;
  logic [0:127]  head;
  logic [CW:0]   credit_sum;

  assign word_valid = (count_q != '0);
  assign word_last  = word_valid && (k_q == LAST_K);
  assign head       = mem_q[rd_ptr_q];
  assign word_data  = word_valid ? head[int'(k_q)*WORD_W +: WORD_W] : '0;
  assign blk_count  = count_q;
  assign overflow   = overflow_q;

  // Credit counts both stored blocks and blocks still inside the cipher pipeline.
  assign credit_sum = {1'b0, count_q} + {1'b0, inflight_q};
  assign can_issue  = (credit_sum < {1'b0, DEPTH_C});

  always_comb begin
    xfer       = word_valid & word_ready;
    pop        = xfer & word_last;
    // A full FIFO can still accept when its head block leaves in the same cycle.
    push       = blk_valid & ((count_q < DEPTH_C) | pop);

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    k_d        = k_q;
    inflight_d = inflight_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (xfer) begin
      k_d = pop ? '0 : k_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (blk_valid && !push) begin
      overflow_d = 1'b1;
    end

    if (issue && !blk_valid && (inflight_q != DEPTH_C)) begin
      inflight_d = inflight_q + 1'b1;
    end else if (!issue && blk_valid && (inflight_q != '0)) begin
      inflight_d = inflight_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      k_q        <= '0;
      inflight_q <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      k_q        <= k_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Block storage needs no reset: contents are only visible while count_q says they are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= blk_data;
    end
  end

endmodule
